// File: rtl/daq_pkg.sv
// Shared word codes, FSM states and helpers
// for the DAQ raw-hit readout generator.
package daq_pkg;

  localparam logic [18:0] HDR_MARK = 19'h0DB0A;
  localparam logic [18:0] TRL_MARK = 19'h0DE0D;
  localparam logic [18:0] LY_ZERO  = 19'h01000;
  localparam logic [18:0] TB_ZERO  = 19'h02000;
  localparam logic [18:0] PAD      = 19'h03000;
  localparam logic [7:0]  TRL2_TAG = 8'b00111010;

  localparam int DEF_NWG = 48;
  localparam int WPL     = DEF_NWG / 12;

  typedef enum logic [3:0] {
    S_IDLE,
    S_POP,
    S_HDR0,
    S_HDR1,
    S_HDR2,
    S_HDR3,
    S_FETCH,
    S_CAPT,
    S_EMIT,
    S_PAD,
    S_TRL0,
    S_TRL1,
    S_TRL2
  } state_t;

  function automatic logic [4:0] clamp_tbins(
    input logic [4:0]  n,
    input int unsigned lim
  );
    logic [31:0] l;
    l = lim;
    if (32'(n) > l) return l[4:0];
    return n;
  endfunction

endpackage

// File: rtl/daq_desc_fifo.sv
// L1A descriptor FIFO, first-word-fall-through.
// Extra pointer bit distinguishes full from empty.
module daq_desc_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp;
  logic [AW:0]  rp;
  logic         do_push;
  logic         do_pop;

  assign full    = (wp[AW] != rp[AW]) &&
                   (wp[AW-1:0] == rp[AW-1:0]);
  assign empty   = (wp == rp);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

endmodule

// File: rtl/daq_readout_gen.sv
// DAQ frame builder: headers, zero-suppressed raw
// timebins, padding and checksummed trailer.
module daq_readout_gen
  import daq_pkg::*;
#(
  parameter int NLY        = 6,
  parameter int NWG        = DEF_NWG,
  parameter int ADDR_W     = 8,
  parameter int MAX_TBINS  = 31,
  parameter int DESC_DEPTH = 4
) (
  input  logic              clk,
  input  logic              hard_rst,
  input  logic              desc_valid,
  output logic              desc_ready,
  input  logic [11:0]       desc_bxn,
  input  logic [11:0]       desc_l1a_cnt,
  input  logic [ADDR_W-1:0] desc_base,
  input  logic [4:0]        fifo_tbins,
  input  logic              zero_suppress,
  output logic [ADDR_W-1:0] raw_adr,
  input  logic [NLY*NWG-1:0] raw_data,
  output logic [18:0]       daq_data,
  output logic              daq_valid,
  input  logic              daq_ready,
  output logic              busy,
  output logic [11:0]       readout_count
);

  localparam int NWPL = NWG / 12;
  localparam int LW   = (NLY > 1) ? $clog2(NLY) : 1;
  localparam int KW   = (NWPL > 1) ? $clog2(NWPL) : 1;
  localparam int FW   = 24 + ADDR_W + 5;

  state_t state, state_n;

  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic [FW-1:0]     fifo_q;
  logic [FW-1:0]     fifo_d;

  logic [11:0]       bxn_r;
  logic [11:0]       cnt_r;
  logic [ADDR_W-1:0] base_r;
  logic [4:0]        tbins_r;
  logic [4:0]        t_r;
  logic              zs_r;
  logic [NLY*NWG-1:0] hold_r;
  logic [LW-1:0]     ly_r;
  logic [KW-1:0]     k_r;
  logic [10:0]       wc_r;
  logic [11:0]       chk_r;

  logic [11:0]       wd [NLY][NWPL];
  logic [NLY-1:0]    lz;
  logic              xfer;
  logic              tb_zero;
  logic              ly_done;
  logic              tb_last;
  logic              more_tb;
  logic              in_trl;

  assign desc_ready = !fifo_full;
  assign fifo_d = {desc_bxn, desc_l1a_cnt, desc_base,
                   clamp_tbins(fifo_tbins, MAX_TBINS)};

  daq_desc_fifo #(
    .W     (FW),
    .DEPTH (DESC_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (hard_rst),
    .push  (desc_valid && desc_ready),
    .wdata (fifo_d),
    .pop   (pop),
    .rdata (fifo_q),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  for (genvar l = 0; l < NLY; l++) begin : g_ly
    assign lz[l] = ~|hold_r[l*NWG +: NWG];
    for (genvar k = 0; k < NWPL; k++) begin : g_wd
      assign wd[l][k] = hold_r[l*NWG + k*12 +: 12];
    end
  end

  assign xfer    = daq_valid && daq_ready;
  assign tb_zero = zs_r && (hold_r == '0);
  assign ly_done = tb_zero || (zs_r && lz[ly_r]) ||
                   (k_r == KW'(NWPL - 1));
  assign tb_last = tb_zero ||
                   (ly_done && ly_r == LW'(NLY - 1));
  assign more_tb = ({1'b0, t_r} + 6'd1) < {1'b0, tbins_r};
  assign in_trl  = (state == S_TRL0) || (state == S_TRL1) ||
                   (state == S_TRL2);
  assign busy    = (state != S_IDLE);
  assign raw_adr = base_r + ADDR_W'(t_r);

  always_ff @(posedge clk or posedge hard_rst) begin
    if (hard_rst) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n   = state;
    pop       = 1'b0;
    daq_valid = 1'b0;
    daq_data  = '0;
    unique case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_n = S_POP;
        end
      end
      S_POP: state_n = S_HDR0;
      S_HDR0: begin
        daq_valid = 1'b1;
        daq_data  = HDR_MARK;
        if (xfer) state_n = S_HDR1;
      end
      S_HDR1: begin
        daq_valid = 1'b1;
        daq_data  = {7'h0D, bxn_r};
        if (xfer) state_n = S_HDR2;
      end
      S_HDR2: begin
        daq_valid = 1'b1;
        daq_data  = {7'h0D, cnt_r};
        if (xfer) state_n = S_HDR3;
      end
      S_HDR3: begin
        daq_valid = 1'b1;
        daq_data  = {8'h0, zs_r, 5'h0, tbins_r};
        if (xfer)
          state_n = (tbins_r == 5'd0) ? S_PAD : S_FETCH;
      end
      S_FETCH: state_n = S_CAPT;
      S_CAPT:  state_n = S_EMIT;
      S_EMIT: begin
        daq_valid = 1'b1;
        if (tb_zero)
          daq_data = TB_ZERO;
        else if (zs_r && lz[ly_r])
          daq_data = LY_ZERO;
        else
          daq_data = {7'b0, wd[ly_r][k_r]};
        if (xfer && tb_last)
          state_n = more_tb ? S_FETCH : S_PAD;
      end
      S_PAD: begin
        // Pad only when the word count is not already 4-aligned
        if (wc_r[1:0] == 2'd0) begin
          state_n = S_TRL0;
        end else begin
          daq_valid = 1'b1;
          daq_data  = PAD;
          if (xfer && wc_r[1:0] == 2'd3) state_n = S_TRL0;
        end
      end
      S_TRL0: begin
        daq_valid = 1'b1;
        daq_data  = TRL_MARK;
        if (xfer) state_n = S_TRL1;
      end
      S_TRL1: begin
        daq_valid = 1'b1;
        daq_data  = {7'h0, chk_r};
        if (xfer) state_n = S_TRL2;
      end
      S_TRL2: begin
        daq_valid = 1'b1;
        daq_data  = {TRL2_TAG, wc_r};
        if (xfer) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge hard_rst) begin
    if (hard_rst) begin
      bxn_r         <= '0;
      cnt_r         <= '0;
      base_r        <= '0;
      tbins_r       <= '0;
      t_r           <= '0;
      zs_r          <= 1'b0;
      hold_r        <= '0;
      ly_r          <= '0;
      k_r           <= '0;
      wc_r          <= '0;
      chk_r         <= '0;
      readout_count <= '0;
    end else begin
      if (pop) {bxn_r, cnt_r, base_r, tbins_r} <= fifo_q;
      if (state == S_POP) begin
        zs_r  <= zero_suppress;
        t_r   <= '0;
        ly_r  <= '0;
        k_r   <= '0;
        wc_r  <= '0;
        chk_r <= '0;
      end
      if (state == S_CAPT) hold_r <= raw_data;
      if (xfer) begin
        wc_r <= wc_r + 11'd1;
        if (!in_trl) chk_r <= chk_r ^ daq_data[11:0];
      end
      if (xfer && state == S_EMIT) begin
        if (tb_last) begin
          t_r  <= t_r + 5'd1;
          ly_r <= '0;
          k_r  <= '0;
        end else if (ly_done) begin
          ly_r <= ly_r + 1'b1;
          k_r  <= '0;
        end else begin
          k_r <= k_r + 1'b1;
        end
      end
      if (xfer && state == S_TRL2)
        readout_count <= readout_count + 12'd1;
    end
  end

endmodule
